// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Steps through DIGITS digits, SCAN_DIV clock cycles per digit. Each slot
// starts with one dead cycle (all anodes off) so the previous digit does not
// ghost. Outputs are registered, so they lag the scan state by one cycle.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank_en,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;
    logic                lz_q;

    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;

    logic                slot_end;
    logic                frame_end;
    logic [DIGITS-1:0]   upper_zero;
    logic                run_zero;
    logic [3:0]          nib;
    logic                dp_bit;
    logic                blank_bit;
    logic                lead_zero;
    logic [6:0]          seg7;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    // Shadow copies of the display data; load replaces them, reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            lz_q    <= 1'b0;
        end else if (load) begin
            val_q   <= value;
            dp_q    <= dp_en;
            blank_q <= blank_en;
            lz_q    <= lz_suppress;
        end
    end

    // Slot boundary and end-of-frame detection.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
    end

    // Slot counter and digit index; loads never disturb the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (slot_end) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Mark digits that sit above the highest nonzero nibble (leading zeros).
    always_comb begin
        upper_zero = '0;
        run_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero && (val_q[4*i +: 4] == 4'h0);
            upper_zero[i] = run_zero;
        end
    end

    // Pick out the active digit's nibble and per-digit flags.
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        lead_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = val_q[4*i +: 4];
                dp_bit    = dp_q[i];
                blank_bit = blank_q[i];
                lead_zero = upper_zero[i] && (i != 0);
            end
        end
    end

    // Hex nibble to active-low g..a pattern.
    always_comb begin
        seg7 = 7'h7F;
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

    // Combine blanking, zero suppression and dp; anodes go dark on the slot's first cycle.
    always_comb begin
        if (blank_bit) begin
            seg_next = 8'hFF;
        end else if (lz_q && lead_zero) begin
            seg_next = {~dp_bit, 7'h7F};
        end else begin
            seg_next = {~dp_bit, seg7};
        end
        an_next = (cnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next;
            an_out     <= an_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4 cycles per slot).
// A position-based model predicts every output cycle; literal checks pin
// the model to hand-worked values.
module tb_seg_scan_driver;

    localparam int DG = 4;
    localparam int SD = 4;

    logic          clk;
    logic          rst;
    logic [15:0]   value;
    logic [3:0]    dp_en;
    logic [3:0]    blank_en;
    logic          lz_suppress;
    logic          load;
    logic [7:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    // Model state: scan position since reset plus shadow copies.
    int          m_pos;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_lz;
    logic        m_valid = 1'b0;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp_en       (dp_en),
        .blank_en    (blank_en),
        .lz_suppress (lz_suppress),
        .load        (load),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the active digit should show, from the display rules.
    function automatic logic [7:0] digitSeg(input int d);
        int hi;
        logic [3:0] n;
        hi = -1;
        for (int i = 0; i < DG; i++)
            if (((m_val >> (4*i)) & 16'hF) != 0) hi = i;
        n = 4'((m_val >> (4*d)) & 16'hF);
        if (m_blank[d]) return 8'hFF;
        if (m_lz && d > hi && d != 0) return m_dp[d] ? 8'h7F : 8'hFF;
        return {~m_dp[d], seg_tab[n]};
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic modelEdge();
        int d;
        int s;
        if (rst) begin
            exp_seg = 8'hFF;
            exp_an  = 4'hF;
            exp_fd  = 1'b0;
            m_pos   = 0;
            m_val   = '0;
            m_dp    = '0;
            m_blank = '0;
            m_lz    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            d       = (m_pos / SD) % DG;
            s       = m_pos % SD;
            exp_an  = (s == 0) ? 4'hF : ~(4'b0001 << d);
            exp_fd  = ((m_pos % (SD*DG)) == (SD*DG - 1));
            exp_seg = digitSeg(d);
            m_pos++;
            if (load) begin
                m_val   = value;
                m_dp    = dp_en;
                m_blank = blank_en;
                m_lz    = lz_suppress;
            end
        end
    endtask

    // Run n clock cycles, comparing DUT against the model on each falling edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            if (m_valid) begin
                checkOutput("model_seg", 32'(seg_out), 32'(exp_seg));
                checkOutput("model_an", 32'(an_out), 32'(exp_an));
                checkOutput("model_fd", 32'(frame_done), 32'(exp_fd));
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dp,
                                 input logic [3:0] bl, input logic lz);
        value       = v;
        dp_en       = dp;
        blank_en    = bl;
        lz_suppress = lz;
        load        = 1'b1;
        tick(1);
        load        = 1'b0;
    endtask

    task automatic checkDigit(input string name, input logic [7:0] seg, input logic [3:0] an);
        checkOutput({name, "_seg"}, 32'(seg_out), 32'(seg));
        checkOutput({name, "_an"}, 32'(an_out), 32'(an));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_en = '0; blank_en = '0; lz_suppress = 1'b0;
        @(negedge clk);
        tick(2);
        checkDigit("reset", 8'hFF, 4'hF);
        checkOutput("reset_fd", 32'(frame_done), 32'd0);

        // Decode pass; load coincides with the first scanning edge.
        rst = 1'b0;
        applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b0);
        checkDigit("dead_start", 8'hC0, 4'hF);
        tick(1);  checkDigit("dec_d0", 8'h8E, 4'hE);
        tick(4);  checkDigit("dec_d1", 8'h88, 4'hD);
        tick(4);  checkDigit("dec_d2", 8'hA4, 4'hB);
        tick(4);  checkDigit("dec_d3", 8'hF9, 4'h7);
        tick(2);  checkOutput("frame_pulse", 32'(frame_done), 32'd1);
        tick(1);  checkOutput("frame_low", 32'(frame_done), 32'd0);

        // Leading-zero suppression, loaded mid-slot.
        applyStimulus(16'h0050, 4'h0, 4'h0, 1'b1);
        tick(16); checkDigit("lz_d0", 8'hC0, 4'hE);
        tick(4);  checkDigit("lz_d1", 8'h92, 4'hD);
        tick(4);  checkDigit("lz_d2", 8'hFF, 4'hB);
        tick(4);  checkDigit("lz_d3", 8'hFF, 4'h7);
        applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1);
        tick(3);  checkDigit("zero_d0", 8'hC0, 4'hE);
        tick(4);  checkDigit("zero_d1", 8'hFF, 4'hD);
        tick(4);  checkDigit("zero_d2", 8'hFF, 4'hB);
        tick(4);  checkDigit("zero_d3", 8'hFF, 4'h7);

        // Decimal point and forced blank.
        applyStimulus(16'h8888, 4'b0100, 4'b1000, 1'b0);
        tick(3);  checkDigit("dp_d0", 8'h80, 4'hE);
        tick(4);  checkDigit("dp_d1", 8'h80, 4'hD);
        tick(4);  checkDigit("dp_d2", 8'h00, 4'hB);
        tick(4);  checkDigit("blank_d3", 8'hFF, 4'h7);

        // Suppressed digit that still carries a decimal point.
        applyStimulus(16'h0003, 4'b0100, 4'b0000, 1'b1);
        tick(3);  checkDigit("lzdp_d0", 8'hB0, 4'hE);
        tick(8);  checkDigit("lzdp_d2", 8'h7F, 4'hB);

        // Reset while digit 2 is lit, with a competing load.
        tick(16); checkOutput("pre_rst_an", 32'(an_out), 32'hB);
        rst = 1'b1;
        value = 16'hFFFF; dp_en = 4'hF; blank_en = 4'h0; lz_suppress = 1'b0; load = 1'b1;
        tick(1);  checkDigit("mid_rst", 8'hFF, 4'hF);
        checkOutput("mid_rst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0; load = 1'b0;
        tick(1);  checkDigit("restart_dead", 8'hC0, 4'hF);
        tick(1);  checkDigit("restart_d0", 8'hC0, 4'hE);

        // Free-running framing.
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
